fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V cores. It replaces the free-running "PC += 4 every clock" fetch with a proper fetch unit:

- a fetch-PC sequencer with redirect (branch/jump/trap target) support;
- a request issuer for a synchronous instruction RAM with one-cycle read latency;
- a QDEPTH-entry prefetch queue that presents instructions, each tagged with its PC, to decode through a valid/ready handshake.

It sits between the instruction memory (ramI) and the decode stage of single-cycle, multicycle and pipelined cores.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC sequencer, 1-cycle RAM issuer and prefetch queue.
// Optional macro FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int          QDEPTH    = 4,
    parameter int          ADDR_W    = 10
) (
    input  logic                         clockCPU,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic                         imem_rden,
    input  logic [31:0]                  imem_q,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instr,
    output logic [31:0]                  instr_pc,
    output logic [31:0]                  fetch_pc,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_tag;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_data [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];

    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_head_valid;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An in-flight request already owns a queue slot, so the queue can never overflow.
    assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_issue = !reset && !redirect && (w_occ < (CW+1)'(QDEPTH));

    assign w_head_valid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = r_inflight && !reset && !redirect && !w_head_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = w_head_valid && instr_ready;
    assign w_push = r_inflight && !redirect && !(w_bypass && instr_ready);

    assign imem_addr   = r_fetch_pc[ADDR_W+1:2];
    assign imem_rden   = w_issue;
    assign fetch_pc    = r_fetch_pc;
    assign q_count     = r_count;
    assign instr_valid = w_head_valid || w_bypass;
    assign instr       = w_bypass ? imem_q : (w_head_valid ? r_q_data[r_head] : 32'h0);
    assign instr_pc    = w_bypass ? r_tag  : (w_head_valid ? r_q_pc[r_head]   : 32'h0);
    assign w_unused    = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clockCPU) begin
        if (reset) begin
            r_fetch_pc <= TEXT_BASE;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag      <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clockCPU) begin
        if (!reset && w_push) begin
            r_q_data[r_tail] <= imem_q;
            r_q_pc[r_tail]   <= r_tag;
        end
    end

    a_no_overflow: assert property (@(posedge clockCPU) disable iff (reset)
        !(w_push && !w_pop && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue with directed timing checks.
module tb_fetch_queue;

    localparam int          QDEPTH = 4;
    localparam int          ADDR_W = 10;
    localparam logic [31:0] TBASE  = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rden;
    logic [31:0]       imem_q = '0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b1;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic [31:0]       fetch_pc;
    logic [2:0]        q_count;

    fetch_queue #(.TEXT_BASE(TBASE), .QDEPTH(QDEPTH), .ADDR_W(ADDR_W)) dut (
        .clockCPU(clk), .reset(reset), .imem_addr(imem_addr), .imem_rden(imem_rden),
        .imem_q(imem_q), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fetch_pc(fetch_pc), .q_count(q_count)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    always @(posedge clk) if (imem_rden) imem_q <= ram[imem_addr];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_next;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_deliv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected stream: sequential word PCs from the last restart point, data straight from RAM.
    task automatic model_topup();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc   = model_next;
            e.data = ram[model_next[ADDR_W+1:2]];
            exp_q.push_back(e);
            model_next = model_next + 32'd4;
        end
    endtask

    task automatic model_load(input logic [31:0] pc);
        exp_q.delete();
        model_next = {pc[31:2], 2'b00};
        model_topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_topup();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic restart(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = rdy;
        model_load(TBASE);
        step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && !redirect) begin
            check("qcount_bound", 32'(q_count <= 3'(QDEPTH)), 32'd1);
            if (!instr_valid) begin
                check("idle_instr", instr, 32'h0);
                check("idle_pc", instr_pc, 32'h0);
            end else if (instr_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e.pc);
                    check("sb_instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        int          d0;
        logic        found;
        logic [31:0] v;

        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        model_load(TBASE);

        // reset state
        repeat (3) step();
        sample();
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_count", q_count, 0);
        check("rst_fetch_pc", fetch_pc, TBASE);
        check("rst_rden", imem_rden, 0);

        // reset release and streaming
        step();
        reset = 1'b0;
        sample();
        check("c0_rden", imem_rden, 1);
        check("c0_addr", imem_addr, 0);
        check("c0_valid", instr_valid, 0);
        d0 = n_deliv;
        step(); sample();
        check("c1_valid", instr_valid, (LAT == 1) ? 1 : 0);
        step(); sample();
        check("c2_valid", instr_valid, 1);
        check("c2_pc", instr_pc, (LAT == 1) ? TBASE + 4 : TBASE);
        repeat (9) step();
        sample();
        check("throughput", n_deliv - d0, 12 - LAT);

        // backpressure
        restart(1'b0);
        repeat (10) step();
        sample();
        check("bp_count", q_count, QDEPTH);
        check("bp_rden", imem_rden, 0);
        check("bp_fetch_pc", fetch_pc, 32'h0040_0010);
        step();
        instr_ready = 1'b1;
        d0 = n_deliv;
        repeat (3) step();
        sample();
        check("bp_drain", n_deliv - d0, 4);

        // redirect with three queued and one in flight
        restart(1'b0);
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        model_load(redirect_pc);
        sample();
        check("r_count_pre", q_count, 3);
        check("r_rden", imem_rden, 0);
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        sample();
        check("r1_count", q_count, 0);
        check("r1_rden", imem_rden, 1);
        check("r1_addr", imem_addr, 10'h040);
        check("r1_valid", instr_valid, 0);
        for (int k = 2; k <= LAT + 1; k++) begin
            step(); sample();
            if (k < LAT + 1) begin
                check("r_early_valid", instr_valid, 0);
            end else begin
                check("r_valid", instr_valid, 1);
                check("r_pc", instr_pc, 32'h0040_0100);
            end
        end

        // redirect coincident with pop and response
        restart(1'b1);
        repeat (6) step();
        v           = $urandom;
        redirect    = 1'b1;
        redirect_pc = v;
        model_load(v);
        sample();
        check("coinc_valid", instr_valid, 1);
        step();
        redirect = 1'b0;
        repeat (10) step();

        // mid-stream reset, then address wrap
        restart(1'b1);
        repeat (4) step();
        instr_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); sample();
            if (q_count == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_q3", found, 1);
        reset = 1'b1;
        model_load(TBASE);
        step();
        reset = 1'b0;
        sample();
        check("mr_valid", instr_valid, 0);
        check("mr_count", q_count, 0);
        check("mr_fetch_pc", fetch_pc, TBASE);
        check("mr_rden", imem_rden, 1);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        model_load(redirect_pc);
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        d0 = n_deliv;
        repeat (8) step();
        sample();
        check("wrap_deliv", 32'(n_deliv - d0 >= 3), 1);

        // randomized traffic
        restart(1'b1);
        for (int n = 0; n < 400; n++) begin
            int r;
            step();
            r           = $urandom_range(0, 99);
            v           = $urandom;
            reset       = (r < 2);
            redirect    = (r < 8);
            redirect_pc = v;
            instr_ready = ($urandom_range(0, 9) < 7);
            if (reset)         model_load(TBASE);
            else if (redirect) model_load(v);
        end
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
